// File: rtl/matrix_store.sv
// Write-side tile store: accepts (row, col)-tagged elements and linearizes them to row<<s | col.
// Writes go out through a one-entry output register so writes can be backpressured; count/done track the tile.
module matrix_store #(
  parameter int MSB = 11,
  parameter int DW  = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic [MSB:0]   row_max,
  input  logic [MSB:0]   col_max,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MSB:0]   in_row,
  input  logic [MSB:0]   in_col,
  input  logic [DW-1:0]  in_data,
  output logic           mem_we,
  input  logic           mem_ready,
  output logic [MSB:0]   mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [MSB+1:0] count
);

  localparam int SW = $clog2(MSB + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [MSB:0]     r_row_max;
  logic [MSB:0]     r_col_max;
  logic [SW-1:0]    r_shift;
  logic [MSB+1:0]   r_total;
  logic [MSB+1:0]   r_count;
  logic             r_err;
  logic             r_full;
  logic [MSB:0]     r_addr;
  logic [DW-1:0]    r_wdata;

  logic [SW-1:0]    w_shift;
  logic             w_ones_run;
  logic [MSB+1:0]   w_rp1;
  logic [MSB+1:0]   w_cp1;
  logic [2*MSB+3:0] w_prod;
  logic [MSB+1:0]   w_total;
  logic             w_run_st;
  logic             w_start_ok;
  logic             w_in_range;
  logic             w_acc;
  logic             w_load;
  logic             w_wr;
  logic             w_last;
  logic [MSB+1:0]   w_count_nx;
  logic [MSB:0]     w_addr;

  // Shift is the number of trailing ones in the column mask; scan stops at the first zero.
  always_comb begin
    w_shift    = '0;
    w_ones_run = 1'b1;
    for (int i = 0; i <= MSB; i++) begin
      if (w_ones_run && col_max[i]) begin
        w_shift = w_shift + SW'(1);
      end else begin
        w_ones_run = 1'b0;
      end
    end
  end

  // Total is one bit wider than an index so a full 2^(MSB+1) tile does not wrap.
  assign w_rp1   = {1'b0, row_max} + (MSB+2)'(1);
  assign w_cp1   = {1'b0, col_max} + (MSB+2)'(1);
  assign w_prod  = {{(MSB+2){1'b0}}, w_rp1} * {{(MSB+2){1'b0}}, w_cp1};
  assign w_total = w_prod[MSB+1:0];

  assign w_run_st   = (r_state == S_RUN);
  assign w_start_ok = start && (r_state != S_RUN);
  assign w_in_range = ((in_row & ~r_row_max) == '0) && ((in_col & ~r_col_max) == '0);
  assign in_ready   = w_run_st && (!r_full || mem_ready);
  assign w_acc      = in_valid && in_ready;
  assign w_load     = w_acc && w_in_range;
  assign w_wr       = r_full && mem_ready;
  assign w_count_nx = r_count + (MSB+2)'(1);
  assign w_last     = w_wr && (w_count_nx == r_total);
  assign w_addr     = (in_row << r_shift) | in_col;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (start)  w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_row_max <= '0;
      r_col_max <= '0;
      r_shift   <= '0;
      r_total   <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_full    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (w_start_ok) begin
      r_row_max <= row_max;
      r_col_max <= col_max;
      r_shift   <= w_shift;
      r_total   <= w_total;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_full    <= 1'b0;
    end else if (w_run_st) begin
      if (w_wr) begin
        r_count <= w_count_nx;
      end
      if (w_acc && !w_in_range) begin
        r_err <= 1'b1;
      end
      // Output register is emptied on tile completion; anything loaded alongside is discarded.
      if (w_last) begin
        r_full <= 1'b0;
      end else if (w_load) begin
        r_full  <= 1'b1;
        r_addr  <= w_addr;
        r_wdata <= in_data;
      end else if (w_wr) begin
        r_full <= 1'b0;
      end
    end
  end

  assign mem_we    = r_full;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = w_run_st;
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: doc/matrix_store.md
# matrix_store

Write-side companion to the linear/2D read counter. It accepts result elements tagged with (row, col) indices over a valid/ready handshake and converts each index pair to a linearized memory address. It then drives a backpressured memory write port and counts completed writes, signalling when a full matrix tile has been stored. It sits between the MAC array output and the result RAM.

## Interface
- `MSB`, 11, MSB of index, address and mask buses.
- `DW`, 16, data width.

- `CLK`  in  1  clock; all state updates on posedge.
- `RST`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a tile; sampled in IDLE or DONE only.
- `row_max`  in  MSB+1  row index mask, 2^r-1; latched on start.
- `col_max`  in  MSB+1  column index mask, 2^c-1; latched on start. Requires r+c <= MSB+1.
- `in_valid`  in  1  element valid.
- `in_ready`  out  1  element accepted when `in_valid && in_ready`.
- `in_row`, `in_col`  in  MSB+1 each  element indices.
- `in_data`  in  DW  element data.
- `mem_we`  out  1  write request valid.
- `mem_ready`  in  1  memory accepts the write when `mem_we && mem_ready`.
- `mem_addr`  out  MSB+1  linear address.
- `mem_wdata`  out  DW  write data.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `err`  out  1  sticky out-of-range flag; cleared on start.
- `count`  out  MSB+2  completed writes this tile.

## Operation
- **States:** IDLE, RUN, DONE. Reset enters IDLE.
- **Reset values:** all outputs 0. Output register empty. Latched masks 0.
- **IDLE → RUN on start:**
  - Latch `row_max` and `col_max`.
  - Compute shift `s` = number of trailing ones in `col_max` (0..MSB+1). The loop stops at the first 0 bit.
  - Clear `count` and `err`.
  - Compute `total` = (`row_max`+1)*(`col_max`+1), MSB+2 bits wide, so a full 2^(MSB+1) tile is representable.
- **RUN, input side:**
  - `in_ready` = !`full` || `mem_ready`. The block has a one-entry output register with `full` flag, so pass-through is allowed on a simultaneous drain.
  - An accepted element is range-checked: it is in range when (`in_row` & ~`row_max`) == 0 and (`in_col` & ~`col_max`) == 0.
  - Out of range: set `err`, drop the element (no write, no count). `in_ready` behaviour is unchanged.
  - In range: load the output register with `mem_addr` = (`in_row` << s) | `in_col` and `mem_wdata` = `in_data`. Set `full`.
- **RUN, output side:**
  - `mem_we` = `full`.
  - On `mem_we && mem_ready`: `count` += 1. Clear `full` unless a new element is loaded in the same cycle.
  - `mem_addr` and `mem_wdata` stay stable while `mem_we && !mem_ready`.
- **RUN → DONE:** on the cycle the write bringing `count` to `total` completes. Elements offered after that are not accepted (`in_ready` = 0 in DONE).
- **DONE:**
  - `done` = 1, `in_ready` = 0, `mem_we` = 0.
  - `count` and `err` hold.
  - `start` → RUN with fresh latch and clears, same as from IDLE.
- **start in RUN:** ignored.
- **Duplicate indices:** not detected. Each one writes and counts.
- **RST mid-tile:** the next cycle is IDLE with the output register discarded. A pending write is abandoned; `mem_we` drops to 0.

## Timing
- **Latency:** element accepted at edge N → `mem_we` with its address and data visible after edge N, i.e. written at edge N+1 if `mem_ready`=1.
- **Throughput:** 1 element/cycle with `mem_ready` held 1.
- **Backpressure:**
  - `mem_ready`=0 with `full`=1 → `in_ready`=0 in the same cycle (combinational from `mem_ready`).
  - No combinational path exists from `in_valid` to `mem_we`.
- **Start:** `start` at edge N → `busy`=1 and `in_ready`=1 after edge N.
- **Completion:** `done` rises the cycle after the final write handshake. `busy` falls in that same cycle.

## Test plan
1. **Row-major stream.** `row_max`=3, `col_max`=3, `mem_ready`=1, 16 elements in row-major order → `mem_addr` 0..15 one per cycle, `count`=16, `done` high one cycle after the last write, `err`=0.
2. **Non-square tile with backpressure.** `row_max`=1, `col_max`=7 (s=3), element (1,5) with `mem_ready` low for 3 cycles → `mem_addr`=13 held stable with `mem_we`=1; `in_ready`=0 while `full`; exactly one write.
3. **Out-of-range element.** Element (4,0) with `row_max`=3 → `err`=1, no `mem_we`, `count` unchanged; following valid elements still written; `err` clears on the next start.
4. **Full-width tile.** `MSB`=3, `row_max`=0, `col_max`=15 → `total`=16, `count` reaches 16 without wrap, DONE entered.
5. **Reset mid-tile.** RST asserted while `full`=1 and `mem_ready`=0 → next cycle `mem_we`=0, `busy`=0, `count`=0; after a new start, address 0 writes correctly.
6. **Simultaneous drain and load.** `mem_ready`=1 and `in_valid`=1 every cycle → no bubble, `in_ready` stays 1, and `count` equals cycles-1 after the first write.
